// File: rtl/nf_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | nf_lsu : single-outstanding load/store unit to the data bus       |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module nf_lsu #(
  parameter int BUS_W = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic             lsu_we,
  input  logic [BUS_W-1:0] lsu_addr,
  input  logic [BUS_W-1:0] lsu_wd,
  input  logic [1:0]       lsu_size,
  input  logic             lsu_unsigned,
  input  logic [AW-1:0]    lsu_rd,
  output logic [BUS_W-1:0] addr_dm,
  output logic [BUS_W-1:0] wd_dm,
  output logic [3:0]       be_dm,
  output logic             we_dm,
  output logic             req_dm,
  input  logic             req_ack_dm,
  input  logic [BUS_W-1:0] rd_dm,
  input  logic             rvalid_dm,
  output logic [AW-1:0]    wa3,
  output logic [BUS_W-1:0] wd3,
  output logic             we3,
  output logic             lsu_misalign,
  output logic             lsu_busy
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_REQ    = 3'd1;
  localparam logic [2:0] c_WAIT_R = 3'd2;
  localparam logic [2:0] c_WB     = 3'd3;
  localparam logic [2:0] c_ERR    = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_we;
  logic [BUS_W-1:0] r_addr;
  logic [BUS_W-1:0] r_wd;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [AW-1:0]    r_rd;
  logic [BUS_W-1:0] r_rdata;
  logic             w_accept;
  logic             w_misalign;
  logic [BUS_W-1:0] w_shift;
  logic [BUS_W-1:0] w_load_ext;
  logic [3:0]       w_be;

  assign w_accept   = lsu_valid && (r_state == c_IDLE);
  assign w_misalign = (lsu_size == 2'd3)
                   || ((lsu_size == 2'd1) && lsu_addr[0])
                   || ((lsu_size == 2'd2) && (lsu_addr[1:0] != 2'b00));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= c_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (w_accept) w_next_state = w_misalign ? c_ERR : c_REQ;
      c_REQ:    if (req_ack_dm) w_next_state = r_we ? c_IDLE : c_WAIT_R;
      c_WAIT_R: if (rvalid_dm) w_next_state = c_WB;
      c_WB:     w_next_state = c_IDLE;
      c_ERR:    w_next_state = c_IDLE;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // Outputs decoded from state; ready is held low while reset is asserted
  always_comb begin
    lsu_ready    = resetn && (r_state == c_IDLE);
    req_dm       = (r_state == c_REQ);
    we3          = (r_state == c_WB) && (r_rd != '0);
    lsu_misalign = (r_state == c_ERR);
    lsu_busy     = (r_state == c_REQ) || (r_state == c_WAIT_R) || (r_state == c_WB);
  end

  // Command capture and load-data capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_rd       <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_we       <= lsu_we;
        r_addr     <= lsu_addr;
        r_wd       <= lsu_wd;
        r_size     <= lsu_size;
        r_unsigned <= lsu_unsigned;
        r_rd       <= lsu_rd;
      end
      if ((r_state == c_WAIT_R) && rvalid_dm) r_rdata <= w_load_ext;
    end
  end

  // Bring the addressed lane down to bit 0, then extend
  assign w_shift = rd_dm >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_load_ext = {{(BUS_W-8){~r_unsigned & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load_ext = {{(BUS_W-16){~r_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: w_load_ext = w_shift;
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_addr[1:0];
      2'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    case (r_size)
      2'd0:    wd_dm = {4{r_wd[7:0]}};
      2'd1:    wd_dm = {2{r_wd[15:0]}};
      default: wd_dm = r_wd;
    endcase
  end

  assign addr_dm = {r_addr[BUS_W-1:2], 2'b00};
  assign be_dm   = req_dm ? w_be : 4'b0000;
  assign we_dm   = req_dm && r_we;
  assign wa3     = r_rd;
  assign wd3     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_nf_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_nf_lsu : directed self-checking bench for nf_lsu               |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module tb_nf_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lsu_valid, lsu_ready, lsu_we, lsu_unsigned;
  logic [31:0] lsu_addr, lsu_wd;
  logic [1:0]  lsu_size;
  logic [4:0]  lsu_rd;
  logic [31:0] addr_dm, wd_dm, rd_dm, wd3;
  logic [3:0]  be_dm;
  logic        we_dm, req_dm, req_ack_dm, rvalid_dm, we3, lsu_misalign, lsu_busy;
  logic [4:0]  wa3;

  int total = 0;
  int bad   = 0;
  int req_cycles;
  logic req_seen, we3_seen;

  nf_lsu #(.BUS_W(32), .AW(5)) dut (
    .clk(clk), .resetn(resetn),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wd(lsu_wd), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_rd(lsu_rd),
    .addr_dm(addr_dm), .wd_dm(wd_dm), .be_dm(be_dm), .we_dm(we_dm),
    .req_dm(req_dm), .req_ack_dm(req_ack_dm), .rd_dm(rd_dm), .rvalid_dm(rvalid_dm),
    .wa3(wa3), .wd3(wd3), .we3(we3),
    .lsu_misalign(lsu_misalign), .lsu_busy(lsu_busy)
  );

  always #5 clk = ~clk;

  // Sticky observers sampled mid-cycle
  always @(negedge clk) begin
    if (req_dm) begin
      req_seen   = 1'b1;
      req_cycles = req_cycles + 1;
    end
    if (we3) we3_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    req_seen   = 1'b0;
    we3_seen   = 1'b0;
    req_cycles = 0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd);
    lsu_we       = we;
    lsu_addr     = addr;
    lsu_wd       = wd;
    lsu_size     = size;
    lsu_unsigned = uns;
    lsu_rd       = rd;
    lsu_valid    = 1'b1;
    step();
    lsu_valid    = 1'b0;
  endtask

  // Load with immediate ack; a bogus rvalid is offered in the ack cycle and must be ignored
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [31:0] exp_wd3);
    clear_obs();
    issue(1'b0, addr, 32'h0, size, uns, rd);
    check({tag, "_req"}, {31'b0, req_dm}, 32'd1);
    req_ack_dm = 1'b1;
    rvalid_dm  = 1'b1;
    rd_dm      = ~rdata;
    step();
    req_ack_dm = 1'b0;
    rd_dm      = rdata;
    step();
    rvalid_dm  = 1'b0;
    if (rd != 5'd0) begin
      check({tag, "_we3"}, {31'b0, we3}, 32'd1);
      check({tag, "_wa3"}, {27'b0, wa3}, {27'b0, rd});
      check({tag, "_wd3"}, wd3, exp_wd3);
    end else begin
      check({tag, "_we3_r0"}, {31'b0, we3}, 32'd0);
      check({tag, "_busy_wb"}, {31'b0, lsu_busy}, 32'd1);
    end
    step();
    check({tag, "_ready"}, {31'b0, lsu_ready}, 32'd1);
    check({tag, "_we3_off"}, {31'b0, we3}, 32'd0);
  endtask

  initial begin
    resetn = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wd = '0;
    lsu_size = 2'd0; lsu_unsigned = 1'b0; lsu_rd = '0;
    req_ack_dm = 1'b0; rd_dm = '0; rvalid_dm = 1'b0;
    clear_obs();
    repeat (3) step();
    check("rst_ready", {31'b0, lsu_ready}, 32'd0);
    check("rst_req", {31'b0, req_dm}, 32'd0);
    check("rst_we3", {31'b0, we3}, 32'd0);
    check("rst_busy", {31'b0, lsu_busy}, 32'd0);
    check("rst_be", {28'b0, be_dm}, 32'd0);
    resetn = 1'b1;
    step();
    check("idle_ready", {31'b0, lsu_ready}, 32'd1);

    // Store word, ack after two wait cycles
    clear_obs();
    issue(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 5'd3);
    check("sw_addr", addr_dm, 32'h100);
    check("sw_be", {28'b0, be_dm}, 32'hF);
    check("sw_wd", wd_dm, 32'hDEADBEEF);
    check("sw_we", {31'b0, we_dm}, 32'd1);
    check("sw_busy", {31'b0, lsu_busy}, 32'd1);
    check("sw_ready_lo", {31'b0, lsu_ready}, 32'd0);
    step();
    step();
    check("sw_hold_addr", addr_dm, 32'h100);
    check("sw_hold_wd", wd_dm, 32'hDEADBEEF);
    req_ack_dm = 1'b1;
    step();
    req_ack_dm = 1'b0;
    check("sw_req_cycles", req_cycles, 32'd3);
    check("sw_ready", {31'b0, lsu_ready}, 32'd1);
    check("sw_no_we3", {31'b0, we3_seen}, 32'd0);

    // Store byte and store half lanes
    issue(1'b1, 32'h103, 32'h000000A5, 2'd0, 1'b0, 5'd0);
    check("sb_be", {28'b0, be_dm}, 32'h8);
    check("sb_wd", wd_dm, 32'hA5A5A5A5);
    check("sb_addr", addr_dm, 32'h100);
    req_ack_dm = 1'b1; step(); req_ack_dm = 1'b0;
    check("sb_ready", {31'b0, lsu_ready}, 32'd1);
    issue(1'b1, 32'h102, 32'h1234BEEF, 2'd1, 1'b0, 5'd0);
    check("sh_be", {28'b0, be_dm}, 32'hC);
    check("sh_wd", wd_dm, 32'hBEEFBEEF);
    req_ack_dm = 1'b1; step(); req_ack_dm = 1'b0;

    // Loads
    do_load("lb_s", 32'h102, 2'd0, 1'b0, 5'd7, 32'h00800000, 32'hFFFFFF80);
    do_load("lb_u", 32'h102, 2'd0, 1'b1, 5'd7, 32'h00800000, 32'h00000080);
    do_load("lh_r0", 32'h202, 2'd1, 1'b0, 5'd0, 32'h80011234, 32'hFFFF8001);
    do_load("lh_s", 32'h200, 2'd1, 1'b0, 5'd3, 32'h12348765, 32'hFFFF8765);
    do_load("lhu", 32'h202, 2'd1, 1'b1, 5'd4, 32'h80011234, 32'h00008001);
    do_load("lw", 32'h204, 2'd2, 1'b0, 5'd5, 32'hCAFEF00D, 32'hCAFEF00D);

    // Misaligned commands
    clear_obs();
    issue(1'b1, 32'h101, 32'h11111111, 2'd2, 1'b0, 5'd1);
    check("mis_w_pulse", {31'b0, lsu_misalign}, 32'd1);
    check("mis_w_ready", {31'b0, lsu_ready}, 32'd0);
    step();
    check("mis_w_pulse_end", {31'b0, lsu_misalign}, 32'd0);
    check("mis_w_idle", {31'b0, lsu_ready}, 32'd1);
    issue(1'b0, 32'h101, 32'h0, 2'd1, 1'b0, 5'd1);
    check("mis_h_pulse", {31'b0, lsu_misalign}, 32'd1);
    step();
    issue(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 5'd1);
    check("mis_sz3_pulse", {31'b0, lsu_misalign}, 32'd1);
    step();
    check("mis_no_req", {31'b0, req_seen}, 32'd0);
    check("mis_no_we3", {31'b0, we3_seen}, 32'd0);

    // Reset while waiting for read data; late rvalid must be dropped
    clear_obs();
    issue(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 5'd9);
    req_ack_dm = 1'b1; step(); req_ack_dm = 1'b0;
    check("rstw_busy", {31'b0, lsu_busy}, 32'd1);
    resetn = 1'b0;
    step();
    check("rstw_ready_lo", {31'b0, lsu_ready}, 32'd0);
    check("rstw_busy_lo", {31'b0, lsu_busy}, 32'd0);
    resetn = 1'b1; rvalid_dm = 1'b1; rd_dm = 32'h55555555;
    step();
    check("rstw_ready", {31'b0, lsu_ready}, 32'd1);
    step();
    rvalid_dm = 1'b0;
    check("rstw_no_we3", {31'b0, we3_seen}, 32'd0);
    check("rstw_still_idle", {31'b0, lsu_ready}, 32'd1);

    // Back-to-back loads with immediate ack and data: 4-cycle issue spacing
    lsu_we = 1'b0; lsu_addr = 32'h300; lsu_size = 2'd2; lsu_unsigned = 1'b0; lsu_rd = 5'd4;
    rd_dm = 32'h00000042; req_ack_dm = 1'b1; rvalid_dm = 1'b1; lsu_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("b2b_ready_%0d", k), {31'b0, lsu_ready}, {31'b0, (k % 4) == 0});
      check($sformatf("b2b_we3_%0d", k), {31'b0, we3}, {31'b0, (k % 4) == 3});
      if ((k % 4) == 3) check($sformatf("b2b_wd3_%0d", k), wd3, 32'h42);
    end
    lsu_valid = 1'b0; req_ack_dm = 1'b0; rvalid_dm = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
